// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction fetch stage that feeds decode. It owns the program counter and
// issues in-order word reads to instruction memory. Returned words are paired
// with the PC of their request and held in a small prefetch FIFO that decode
// drains. A redirect flushes everything buffered, remembers how many in-flight
// responses must be thrown away, and restarts fetch at the new target.
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   redirect           flush and restart fetch at redirect_pc
//   redirect_pc        new fetch address, low two bits ignored
//   imem_req_valid     fetch request valid toward instruction memory
//   imem_req_ready     memory accepts the request this cycle
//   imem_req_addr      word-aligned fetch address
//   imem_resp_valid    read data returned (in request order)
//   imem_resp_data     returned instruction word
//   instr_valid        FIFO head valid toward decode
//   instr_ready        decode consumes the head this cycle
//   instr, instr_pc    head instruction word and its PC
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] fetch_pc;

  logic [DATA_WIDTH-1:0] fifo_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_word [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [PW-1:0]         aq_rd;
  logic [PW-1:0]         aq_wr;

  logic [CW-1:0] pending;
  logic [CW-1:0] discard;
  logic [CW-1:0] pending_nxt;
  logic [CW-1:0] discard_nxt;

  logic [CW+1:0] credits_used;
  logic          req_fire;
  logic          resp_known;
  logic          resp_drop;
  logic          resp_push;
  logic          pop;
  logic          unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Every buffered word and every outstanding response holds one credit, so
  // a new request is only issued when it is guaranteed a FIFO slot.
  assign credits_used   = {2'b00, count} + {2'b00, pending} + {2'b00, discard};
  assign imem_req_valid = !rst && !redirect && (credits_used < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  // Responses that arrive during a redirect, or while stale ones are still
  // owed, are dropped instead of buffered.
  assign resp_known = imem_resp_valid && (pending != '0 || discard != '0);
  assign resp_drop  = resp_known && (redirect || discard != '0);
  assign resp_push  = resp_known && !resp_drop;
  assign pop        = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_word[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

  // Program counter: a redirect always wins, otherwise advance one word per
  // accepted request, wrapping naturally at the top of the address space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + DATA_WIDTH'(4);
    end
  end

  // Outstanding-response bookkeeping. On a redirect every pending response
  // becomes one to discard, less any response consumed in that same cycle.
  // Otherwise a response retires a discard first, then a pending request.
  always_comb begin
    pending_nxt = pending;
    discard_nxt = discard;
    if (redirect) begin
      pending_nxt = '0;
      discard_nxt = discard + pending - CW'(resp_known);
    end else begin
      if (resp_known) begin
        if (discard != '0) begin
          discard_nxt = discard - CW'(1);
        end else begin
          pending_nxt = pending - CW'(1);
        end
      end
      if (req_fire) begin
        pending_nxt = pending_nxt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      discard <= '0;
    end else begin
      pending <= pending_nxt;
      discard <= discard_nxt;
    end
  end

  // Address queue pointers. The queue is not flushed on redirect because
  // dropped responses still have to retire their PC entries in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_rd <= '0;
      aq_wr <= '0;
    end else begin
      if (req_fire) begin
        aq_wr <= aq_wr + PW'(1);
      end
      if (resp_known) begin
        aq_rd <= aq_rd + PW'(1);
      end
    end
  end

  // Address queue storage: needs no reset, it is only read behind aq_rd.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr_q[aq_wr] <= fetch_pc;
    end
  end

  // Prefetch FIFO control. A simultaneous push and pop leaves the count
  // unchanged; a redirect empties the FIFO regardless of any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (resp_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (resp_push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !resp_push) begin
        count <= count - CW'(1);
      end
    end
  end

  // FIFO storage: each word is stored next to the PC its request carried.
  always_ff @(posedge clk) begin
    if (resp_push) begin
      fifo_pc[wr_ptr]   <= addr_q[aq_rd];
      fifo_word[wr_ptr] <= imem_resp_data;
    end
  end

  // A response with no outstanding request means the memory broke protocol.
  property p_no_orphan_resp;
    @(posedge clk) disable iff (rst)
      imem_resp_valid |-> (pending != '0 || discard != '0);
  endproperty
  a_no_orphan_resp: assert property (p_no_orphan_resp);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A memory model answers accepted
// requests after a fixed latency with word = addr ^ 32'hA5A5_0000. A
// queue-based reference model tracks buffered instructions and in-flight
// fetches (each flagged stale once a redirect passes it) and predicts every
// DUT output each cycle. A second instance with a high RESET_PC exercises
// address wrap-around.
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        w_rst;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  fetch_queue #(.DATA_WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_queue #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(w_rst), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_resp_valid(w_resp_valid),
    .imem_resp_data(w_resp_data), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
  typedef struct { logic [31:0] pc; logic stale; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mem_req_t;

  entry_t   fifo_q[$];
  flight_t  flight_q[$];
  mem_req_t mem_q[$];
  logic [31:0] model_pc;

  int checks = 0;
  int passed = 0;
  int cyc;
  int lat;
  int accepted;
  int first_req_cyc;
  int first_valid_cyc;
  logic        armed;
  logic        armed_seen;
  logic [31:0] armed_pc;
  logic        last_req_valid;
  logic [31:0] last_req_addr;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Hold the main DUT in reset, check the reset-time outputs, clear the
  // models and release reset just after a rising edge so the following
  // cycle is cycle 1.
  task automatic resetDut(input int latency);
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    #1;
    checkOutput("rst_req_valid", imem_req_valid, 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_instr_valid", instr_valid, 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    fifo_q.delete();
    flight_q.delete();
    mem_q.delete();
    model_pc = 32'h0;
    cyc = 0;
    lat = latency;
    accepted = 0;
    first_req_cyc = -1;
    first_valid_cyc = -1;
    armed = 1'b0;
    armed_seen = 1'b0;
    armed_pc = '0;
    #1 rst = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the reference model, then advance memory and model at the
  // rising edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic iready, input logic mready);
    logic        exp_req;
    logic        resp;
    logic        dut_fire;
    logic [31:0] dut_addr;
    logic [31:0] rdata;
    int          fsize;
    flight_t     f;
    @(negedge clk);
    cyc++;
    redirect = redir;
    redirect_pc = rpc;
    instr_ready = iready;
    imem_req_ready = mready;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata = resp ? (mem_q[0].addr ^ XOR_KEY) : $urandom;
    imem_resp_valid = resp;
    imem_resp_data = rdata;
    #1;
    fsize = fifo_q.size();
    exp_req = !redir && ((fsize + flight_q.size()) < DEPTH);
    checkOutput("req_valid", imem_req_valid, exp_req);
    if (exp_req) checkOutput("req_addr", imem_req_addr, model_pc);
    checkOutput("instr_valid", instr_valid, fsize > 0);
    if (fsize > 0) begin
      checkOutput("instr", instr, fifo_q[0].word);
      checkOutput("instr_pc", instr_pc, fifo_q[0].pc);
    end
    last_req_valid = imem_req_valid;
    last_req_addr = imem_req_addr;
    if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (armed && !armed_seen && instr_valid) begin
      armed_seen = 1'b1;
      armed_pc = instr_pc;
    end
    dut_fire = imem_req_valid && mready;
    dut_addr = imem_req_addr;
    @(posedge clk);
    if (dut_fire) accepted++;
    if (resp) void'(mem_q.pop_front());
    if (dut_fire) mem_q.push_back('{addr: dut_addr, due: cyc + lat});
    if (redir) begin
      fifo_q.delete();
      foreach (flight_q[i]) flight_q[i].stale = 1'b1;
      if (resp && flight_q.size() > 0) void'(flight_q.pop_front());
      model_pc = {rpc[31:2], 2'b00};
    end else begin
      if (fsize > 0 && iready) void'(fifo_q.pop_front());
      if (resp && flight_q.size() > 0) begin
        f = flight_q.pop_front();
        if (!f.stale) fifo_q.push_back('{pc: f.pc, word: rdata});
      end
      if (exp_req && mready) begin
        flight_q.push_back('{pc: model_pc, stale: 1'b0});
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  logic [31:0] wrap_exp [4];
  logic [31:0] w_addrs[$];
  logic [31:0] w_pcs[$];
  logic [31:0] w_words[$];

  // Main sequence: directed scenarios, randomized phases, then the
  // wrap-around instance, followed by the summary.
  initial begin
    w_rst = 1'b1;
    w_redirect = 1'b0;
    w_redirect_pc = '0;
    w_req_ready = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_data = '0;
    w_instr_ready = 1'b0;

    // Streaming with 1-cycle memory and decode always ready.
    resetDut(1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("first_req_cycle", first_req_cyc, 32'd1);
    checkOutput("first_instr_cycle", first_valid_cyc, 32'd3);

    // Decode stalled: credits must stop fetch at DEPTH, then drain cleanly.
    resetDut(1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("credit_stop_count", accepted, DEPTH);
    checkOutput("credit_stop_valid", last_req_valid, 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // 3-cycle memory, redirect to 0x100 with two requests in flight.
    resetDut(3);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("inflight_before_redirect", accepted, 32'd2);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
    armed = 1'b1;
    checkOutput("redirect_next_addr_pre", model_pc, 32'h100);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("redirect_seen", armed_seen, 32'd1);
    checkOutput("redirect_first_pc", armed_pc, 32'h100);

    // Redirect to an unaligned target while a response lands in that cycle.
    resetDut(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h203, 1'b1, 1'b1);
    armed = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("unaligned_req_valid", last_req_valid, 32'd1);
    checkOutput("unaligned_req_addr", last_req_addr, 32'h200);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("unaligned_first_pc", armed_pc, 32'h200);

    // Reset mid-stream with three instructions buffered.
    resetDut(1);
    for (int i = 0; i < 10 && fifo_q.size() < 3; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("buffered_before_rst", instr_valid, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_instr_valid", instr_valid, 32'd0);
    checkOutput("midrst_req_valid", imem_req_valid, 32'd0);
    resetDut(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("restart_addr", last_req_addr, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized phases: random latency, back-pressure and redirects.
    for (int p = 0; p < 6; p++) begin
      resetDut(int'($urandom_range(1, 3)));
      for (int i = 0; i < 300; i++) begin
        applyStimulus(($urandom_range(0, 99) < 5), $urandom,
                      ($urandom_range(0, 99) < 70),
                      ($urandom_range(0, 99) < 70));
      end
    end
    rst = 1'b1;

    // Wrap-around instance, free-running with a 1-cycle memory.
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;
    #1;
    checkOutput("wrap_rst_addr", w_req_addr, WRAP_PC);
    @(posedge clk);
    #1 w_rst = 1'b0;
    begin
      logic        w_pend;
      logic [31:0] w_pend_addr;
      logic        acc;
      logic [31:0] acc_addr;
      w_pend = 1'b0;
      w_pend_addr = '0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        w_req_ready = 1'b1;
        w_instr_ready = 1'b1;
        w_resp_valid = w_pend;
        w_resp_data = w_pend_addr ^ XOR_KEY;
        #1;
        if (w_req_valid) w_addrs.push_back(w_req_addr);
        if (w_instr_valid) begin
          w_pcs.push_back(w_instr_pc);
          w_words.push_back(w_instr);
        end
        acc = w_req_valid;
        acc_addr = w_req_addr;
        @(posedge clk);
        w_pend = acc;
        w_pend_addr = acc_addr;
      end
    end
    checkOutput("wrap_req_count", w_addrs.size() >= 4, 32'd1);
    checkOutput("wrap_instr_count", w_pcs.size() >= 4, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < w_addrs.size()) checkOutput("wrap_req_addr", w_addrs[i], wrap_exp[i]);
      if (i < w_pcs.size()) begin
        checkOutput("wrap_instr_pc", w_pcs[i], wrap_exp[i]);
        checkOutput("wrap_instr", w_words[i], wrap_exp[i] ^ XOR_KEY);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
